// File: rtl/nav_input_pkg.sv
// Shared types and constants for the navigation-button conditioning stage.
// Holds the FSM encoding, direction indices, default timing and the move decode.
package nav_input_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_HOLD    = 2'd1,
    ST_REPEAT  = 2'd2,
    ST_LOCKOUT = 2'd3
  } nav_state_t;

  localparam int NUM_DIRS  = 4;
  localparam int DIR_UP    = 0;
  localparam int DIR_DOWN  = 1;
  localparam int DIR_LEFT  = 2;
  localparam int DIR_RIGHT = 3;

  localparam int DEF_DEBOUNCE_CYCLES = 1_000_000;
  localparam int DEF_HOLD_CYCLES     = 50_000_000;
  localparam int DEF_REPEAT_CYCLES   = 20_000_000;
  localparam int DEF_CNT_W           = 26;

  // One-hot direction to {row_en, col_en, add_n}; add_n=1 means decrement.
  function automatic logic [2:0] dir_decode(input logic [NUM_DIRS-1:0] dir_oh);
    logic row;
    logic col;
    logic dec;
    row = dir_oh[DIR_UP] | dir_oh[DIR_DOWN];
    col = dir_oh[DIR_LEFT] | dir_oh[DIR_RIGHT];
    dec = dir_oh[DIR_UP] | dir_oh[DIR_LEFT];
    return {row, col, dec};
  endfunction

endpackage

// File: rtl/nav_input_btn_debounce.sv
// Two-flop synchroniser followed by a stable-run counter for one raw button.
// The level only changes once the synchronised input has differed for DEBOUNCE_CYCLES.
module btn_debounce
  import nav_input_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int CNT_W           = DEF_CNT_W
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic level
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync_p0;
  logic             sync_p1;
  logic [CNT_W-1:0] cnt;

  // stage p0/p1: metastability guard
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
    end else begin
      sync_p0 <= btn;
      sync_p1 <= sync_p0;
    end
  end

  // stage p2: debounced level
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt   <= '0;
      level <= 1'b0;
    end else if (sync_p1 == level) begin
      cnt <= '0;
    end else if (cnt == CNT_LAST) begin
      cnt   <= '0;
      level <= sync_p1;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/nav_input.sv
// Debounces five board buttons and turns directions into fire pulses with
// auto-repeat, plus a one-shot select pulse for the centre button.
module nav_input
  import nav_input_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int HOLD_CYCLES     = DEF_HOLD_CYCLES,
  parameter int REPEAT_CYCLES   = DEF_REPEAT_CYCLES,
  parameter int CNT_W           = DEF_CNT_W
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_up,
  input  logic btn_down,
  input  logic btn_left,
  input  logic btn_right,
  input  logic btn_c,
  output logic row_en,
  output logic col_en,
  output logic add_n,
  output logic fire,
  output logic select
);

  localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_CYCLES - 1);

  logic [NUM_DIRS-1:0] dir_raw;
  logic [NUM_DIRS-1:0] dir_lvl;
  logic                c_lvl;
  logic                c_lvl_q;

  assign dir_raw[DIR_UP]    = btn_up;
  assign dir_raw[DIR_DOWN]  = btn_down;
  assign dir_raw[DIR_LEFT]  = btn_left;
  assign dir_raw[DIR_RIGHT] = btn_right;

  for (genvar i = 0; i < NUM_DIRS; i++) begin : g_dir_db
    btn_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_W          (CNT_W)
    ) u_db (
      .clk  (clk),
      .rst  (rst),
      .btn  (dir_raw[i]),
      .level(dir_lvl[i])
    );
  end

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W          (CNT_W)
  ) u_db_c (
    .clk  (clk),
    .rst  (rst),
    .btn  (btn_c),
    .level(c_lvl)
  );

  nav_state_t          state_q;
  nav_state_t          state_d;
  logic [NUM_DIRS-1:0] held_q;
  logic [NUM_DIRS-1:0] held_d;
  logic [CNT_W-1:0]    cnt_q;
  logic [CNT_W-1:0]    cnt_d;
  logic                fire_d;
  logic [2:0]          qual_d;
  logic                any_dir;
  logic                held_on;
  logic                other_on;

  assign any_dir  = |dir_lvl;
  assign held_on  = |(dir_lvl & held_q);
  assign other_on = |(dir_lvl & ~held_q);

  // Release wins over a simultaneous second press; a second press while held locks out.
  always_comb begin
    state_d = state_q;
    held_d  = held_q;
    cnt_d   = cnt_q;
    fire_d  = 1'b0;
    qual_d  = 3'b000;
    case (state_q)
      ST_IDLE: begin
        if ($onehot(dir_lvl)) begin
          held_d  = dir_lvl;
          fire_d  = 1'b1;
          qual_d  = dir_decode(dir_lvl);
          cnt_d   = '0;
          state_d = ST_HOLD;
        end else if (any_dir) begin
          state_d = ST_LOCKOUT;
        end
      end
      ST_HOLD, ST_REPEAT: begin
        if (!held_on) begin
          cnt_d   = '0;
          state_d = ST_IDLE;
        end else if (other_on) begin
          cnt_d   = '0;
          state_d = ST_LOCKOUT;
        end else if (cnt_q == ((state_q == ST_HOLD) ? HOLD_LAST : REPEAT_LAST)) begin
          fire_d  = 1'b1;
          qual_d  = dir_decode(held_q);
          cnt_d   = '0;
          state_d = ST_REPEAT;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_LOCKOUT: begin
        if (!any_dir) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // stage p3: registered strobes and qualifiers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      held_q  <= '0;
      cnt_q   <= '0;
      fire    <= 1'b0;
      row_en  <= 1'b0;
      col_en  <= 1'b0;
      add_n   <= 1'b0;
      select  <= 1'b0;
      c_lvl_q <= 1'b0;
    end else begin
      state_q                 <= state_d;
      held_q                  <= held_d;
      cnt_q                   <= cnt_d;
      fire                    <= fire_d;
      {row_en, col_en, add_n} <= qual_d;
      select                  <= c_lvl & ~c_lvl_q;
      c_lvl_q                 <= c_lvl;
    end
  end

endmodule

// File: tb/tb_nav_input.sv
// Bench for nav_input: directed scenarios with literal timing plus a random
// phase, all checked each cycle against a schedule-based reference model.
module tb_nav_input;
  import nav_input_pkg::*;

  localparam int D = 4;
  localparam int H = 16;
  localparam int R = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic btn_up = 1'b0, btn_down = 1'b0, btn_left = 1'b0, btn_right = 1'b0, btn_c = 1'b0;
  logic row_en, col_en, add_n, fire, select;

  nav_input #(
    .DEBOUNCE_CYCLES(D),
    .HOLD_CYCLES    (H),
    .REPEAT_CYCLES  (R),
    .CNT_W          (DEF_CNT_W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .btn_up   (btn_up),
    .btn_down (btn_down),
    .btn_left (btn_left),
    .btn_right(btn_right),
    .btn_c    (btn_c),
    .row_en   (row_en),
    .col_en   (col_en),
    .add_n    (add_n),
    .fire     (fire),
    .select   (select)
  );

  always #5 clk = ~clk;

  int   n_cmp = 0;
  int   n_bad = 0;
  int   tcyc  = 0;
  logic chk_en = 1'b0;

  always @(posedge clk) tcyc <= tcyc + 1;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, tcyc);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Reference model: delay line for sync, run-length debounce, absolute fire schedule.
  logic [4:0] raw;
  logic [4:0] m_s1 = '0, m_s2 = '0, m_lvl = '0;
  int         m_run[5];
  logic       m_cprev = 1'b0;
  int         m_mode = 0;
  int         m_held = 0;
  int         m_next = 0;
  int         m_n;
  logic       e_fire = 1'b0, e_row = 1'b0, e_col = 1'b0, e_add = 1'b0, e_sel = 1'b0;

  assign raw = {btn_c, btn_right, btn_left, btn_down, btn_up};

  always @(posedge clk) begin
    if (rst) begin
      m_s1 = '0; m_s2 = '0; m_lvl = '0; m_cprev = 1'b0; m_mode = 0;
      for (int b = 0; b < 5; b++) m_run[b] = 0;
      e_fire = 1'b0; e_row = 1'b0; e_col = 1'b0; e_add = 1'b0; e_sel = 1'b0;
    end else begin
      e_fire = 1'b0; e_row = 1'b0; e_col = 1'b0; e_add = 1'b0;
      e_sel   = m_lvl[4] & ~m_cprev;
      m_cprev = m_lvl[4];
      m_n = int'(m_lvl[0]) + int'(m_lvl[1]) + int'(m_lvl[2]) + int'(m_lvl[3]);
      case (m_mode)
        0: begin
          if (m_n == 1) begin
            for (int b = 0; b < 4; b++) if (m_lvl[b]) m_held = b;
            e_fire = 1'b1;
            m_next = tcyc + 1 + H;
            m_mode = 1;
          end else if (m_n > 1) begin
            m_mode = 2;
          end
        end
        1: begin
          if (!m_lvl[m_held]) m_mode = 0;
          else if (m_n > 1) m_mode = 2;
          else if (tcyc + 1 == m_next) begin
            e_fire = 1'b1;
            m_next = tcyc + 1 + R;
          end
        end
        default: if (m_n == 0) m_mode = 0;
      endcase
      if (e_fire) begin
        e_row = (m_held == 0) || (m_held == 1);
        e_col = (m_held == 2) || (m_held == 3);
        e_add = (m_held == 0) || (m_held == 2);
      end
      for (int b = 0; b < 5; b++) begin
        if (m_s2[b] != m_lvl[b]) begin
          m_run[b]++;
          if (m_run[b] == D) begin
            m_lvl[b] = m_s2[b];
            m_run[b] = 0;
          end
        end else begin
          m_run[b] = 0;
        end
      end
      m_s2 = m_s1;
      m_s1 = raw;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("model_fire", fire, e_fire);
      check("model_row_en", row_en, e_row);
      check("model_col_en", col_en, e_col);
      check("model_add_n", add_n, e_add);
      check("model_select", select, e_sel);
    end
  end

  int         fire_t[$];
  logic [2:0] fire_q[$];
  int         sel_t[$];
  int         mfire_t[$];

  always @(negedge clk) begin
    if (fire) begin
      fire_t.push_back(tcyc);
      fire_q.push_back({row_en, col_en, add_n});
    end
    if (select) sel_t.push_back(tcyc);
    if (e_fire) mfire_t.push_back(tcyc);
  end

  task automatic clear_logs();
    fire_t.delete();
    fire_q.delete();
    sel_t.delete();
    mfire_t.delete();
  endtask

  int exp_up[4] = '{7, 23, 31, 39};

  initial begin
    int base;
    int k;
    rst = 1'b1;
    step(3);
    rst = 1'b0;
    chk_en = 1'b1;
    @(negedge clk);
    check("reset_outputs", {fire, select, row_en, col_en, add_n}, 0);

    // Held up: first pulse, hold delay, then repeat period.
    @(posedge clk); #1;
    clear_logs();
    btn_up = 1'b1;
    base = tcyc;
    step(41);
    check("up_fire_count", fire_t.size(), 4);
    for (int i = 0; i < 4 && i < fire_t.size(); i++) check("up_fire_time", fire_t[i] - base, exp_up[i]);
    if (fire_q.size() > 0) check("up_qual", fire_q[0], 3'b101);
    check("up_model_count", mfire_t.size(), 4);
    if (mfire_t.size() > 0) check("up_model_first", mfire_t[0] - base, 7);
    btn_up = 1'b0;
    step(20);

    // Glitch shorter than the debounce window.
    clear_logs();
    btn_right = 1'b1;
    step(3);
    btn_right = 1'b0;
    step(15);
    check("glitch_fires", fire_t.size(), 0);
    check("glitch_selects", sel_t.size(), 0);

    // Short left press: single move, no repeat.
    clear_logs();
    btn_left = 1'b1;
    base = tcyc;
    step(10);
    btn_left = 1'b0;
    step(25);
    check("left_fire_count", fire_t.size(), 1);
    if (fire_t.size() > 0) check("left_fire_time", fire_t[0] - base, 7);
    if (fire_q.size() > 0) check("left_qual", fire_q[0], 3'b011);
    check("left_state_idle", int'(dut.state_q), int'(ST_IDLE));

    // Two directions together lock out until everything is released.
    clear_logs();
    btn_up = 1'b1;
    btn_down = 1'b1;
    step(20);
    check("lock_both", fire_t.size(), 0);
    btn_down = 1'b0;
    step(20);
    check("lock_up_only", fire_t.size(), 0);
    btn_up = 1'b0;
    step(20);
    check("lock_released", fire_t.size(), 0);
    btn_down = 1'b1;
    base = tcyc;
    step(12);
    check("down_fire_count", fire_t.size(), 1);
    if (fire_t.size() > 0) check("down_fire_time", fire_t[0] - base, 7);
    if (fire_q.size() > 0) check("down_qual", fire_q[0], 3'b100);
    btn_down = 1'b0;
    step(20);

    // Reset in the middle of auto-repeat discards the press.
    clear_logs();
    btn_down = 1'b1;
    base = tcyc;
    step(35);
    check("rep_fire_count", fire_t.size(), 3);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    base = tcyc;
    clear_logs();
    @(negedge clk);
    check("rst_mid_outputs", {fire, select, row_en, col_en, add_n}, 0);
    step(20);
    check("rst_refire_count", fire_t.size(), 1);
    if (fire_t.size() > 0) check("rst_refire_time", fire_t[0] - base, 7);
    btn_down = 1'b0;
    step(20);

    // Centre press alongside a held direction.
    clear_logs();
    btn_right = 1'b1;
    step(2);
    btn_c = 1'b1;
    base = tcyc;
    step(40);
    btn_c = 1'b0;
    step(10);
    btn_right = 1'b0;
    step(25);
    check("sel_count", sel_t.size(), 1);
    if (sel_t.size() > 0) check("sel_time", sel_t[0] - base, 7);
    check("right_min_fires", int'(fire_t.size() >= 3), 1);
    if (fire_t.size() >= 3) begin
      check("right_fire0", fire_t[0] - (base - 2), 7);
      check("right_fire1", fire_t[1] - (base - 2), 23);
      check("right_fire2", fire_t[2] - (base - 2), 31);
    end
    if (fire_q.size() > 0) check("right_qual", fire_q[0], 3'b010);

    // Random phase: toggles of random duration, occasional reset.
    repeat (160) begin
      k = $urandom_range(0, 9);
      case (k)
        0: btn_up    = ~btn_up;
        1: btn_down  = ~btn_down;
        2: btn_left  = ~btn_left;
        3: btn_right = ~btn_right;
        4: btn_c     = ~btn_c;
        8: begin
          btn_up = 1'b0; btn_down = 1'b0; btn_left = 1'b0; btn_right = 1'b0; btn_c = 1'b0;
        end
        9: if ($urandom_range(0, 3) == 0) begin
          rst = 1'b1;
          step(1);
          rst = 1'b0;
        end
        default: ;
      endcase
      step($urandom_range(1, 40));
    end
    btn_up = 1'b0; btn_down = 1'b0; btn_left = 1'b0; btn_right = 1'b0; btn_c = 1'b0;
    step(30);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
